// File: rtl/etapa_ex_pkg.sv
// etapa_ex_pkg: shared widths and ALU operation codes for the execute stage and ALU control decoder
package etapa_ex_pkg;
  localparam int DEF_NB_DATA = 32;
  localparam int DEF_NB_ALU_CONTROL = 4;
  localparam int DEF_NB_REG_ADDR = 5;
  localparam int DEF_NB_SHAMT = 5;
  localparam logic [3:0] ALU_SLL = 4'b0000;
  localparam logic [3:0] ALU_SRL = 4'b0001;
  localparam logic [3:0] ALU_SRA = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0011;
  localparam logic [3:0] ALU_ADDU = 4'b0110;
  localparam logic [3:0] ALU_SUBU = 4'b0111;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1011;
  localparam logic [3:0] ALU_SLT = 4'b1100;
endpackage

// File: rtl/etapa_ex_alu.sv
// alu: combinational ALU (a, b, shamt, code -> result, zero); shifts act on b, undefined codes give 0
module alu
  import etapa_ex_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_ALU_CONTROL = DEF_NB_ALU_CONTROL,
  parameter int NB_SHAMT = DEF_NB_SHAMT
) (
  input  logic [NB_DATA-1:0]        a,
  input  logic [NB_DATA-1:0]        b,
  input  logic [NB_SHAMT-1:0]       shamt,
  input  logic [NB_ALU_CONTROL-1:0] code,
  output logic [NB_DATA-1:0]        result,
  output logic                      zero
);
  always_comb begin
    result = '0;
    case (code)
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $signed(b) >>> shamt;
      ALU_LUI:  result = b << 16;
      ALU_ADDU: result = a + b;
      ALU_SUBU: result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(NB_DATA-1){1'b0}}, $signed(a) < $signed(b)};
      default:  result = '0;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/etapa_ex.sv
// etapa_ex: MIPS execute stage; ALU on ID/EX operands, EX/MEM register with stall/flush, optional forwarding (EX_FORWARDING_EN)
// Ports: i_clk/i_rst (async active-high), i_valid/i_stall/i_flush, ALU code and operands, control bits,
// MEM/WB forwarding source (i_wb_*), registered EX/MEM outputs o_*.
module etapa_ex
  import etapa_ex_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_ALU_CONTROL = DEF_NB_ALU_CONTROL,
  parameter int NB_REG_ADDR = DEF_NB_REG_ADDR,
  parameter int NB_SHAMT = DEF_NB_SHAMT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [NB_ALU_CONTROL-1:0] i_alu_code,
  input  logic [NB_DATA-1:0]        i_dato_rs,
  input  logic [NB_DATA-1:0]        i_dato_rt,
  input  logic [NB_DATA-1:0]        i_imm,
  input  logic [NB_SHAMT-1:0]       i_shamt,
  input  logic                      i_alu_src,
  input  logic                      i_shift_var,
  input  logic [NB_REG_ADDR-1:0]    i_rs_addr,
  input  logic [NB_REG_ADDR-1:0]    i_rt_addr,
  input  logic [NB_REG_ADDR-1:0]    i_reg_dst_addr,
  input  logic                      i_reg_write,
  input  logic                      i_mem_read,
  input  logic                      i_mem_write,
  input  logic                      i_branch,
  input  logic                      i_wb_reg_write,
  input  logic [NB_REG_ADDR-1:0]    i_wb_addr,
  input  logic [NB_DATA-1:0]        i_wb_data,
  output logic                      o_valid,
  output logic [NB_DATA-1:0]        o_alu_result,
  output logic [NB_DATA-1:0]        o_dato_rt,
  output logic [NB_REG_ADDR-1:0]    o_reg_dst_addr,
  output logic                      o_reg_write,
  output logic                      o_mem_read,
  output logic                      o_mem_write,
  output logic                      o_zero,
  output logic                      o_branch_taken
);
  logic [NB_DATA-1:0] rs, rt, b, result;
  logic [NB_SHAMT-1:0] shamt;
  logic zero, bubble;
`ifdef EX_FORWARDING_EN
  // a load's EX/MEM result is an address, not data, so it is never forwarded
  logic ex_fwd_ok;
  assign ex_fwd_ok = o_valid & o_reg_write & ~o_mem_read;
  assign rs = ex_fwd_ok && o_reg_dst_addr == i_rs_addr && i_rs_addr != '0 ? o_alu_result :
              i_wb_reg_write && i_wb_addr == i_rs_addr && i_rs_addr != '0 ? i_wb_data : i_dato_rs;
  assign rt = ex_fwd_ok && o_reg_dst_addr == i_rt_addr && i_rt_addr != '0 ? o_alu_result :
              i_wb_reg_write && i_wb_addr == i_rt_addr && i_rt_addr != '0 ? i_wb_data : i_dato_rt;
`else
  logic unused_fwd;
  assign unused_fwd = ^{i_rs_addr, i_rt_addr, i_wb_reg_write, i_wb_addr, i_wb_data};
  assign rs = i_dato_rs;
  assign rt = i_dato_rt;
`endif
  assign b = i_alu_src ? i_imm : rt;
  assign shamt = i_shift_var ? rs[NB_SHAMT-1:0] : i_shamt;
  alu #(.NB_DATA(NB_DATA), .NB_ALU_CONTROL(NB_ALU_CONTROL), .NB_SHAMT(NB_SHAMT)) u_alu (
    .a(rs), .b(b), .shamt(shamt), .code(i_alu_code), .result(result), .zero(zero)
  );
  // an invalid instruction loads the same bubble as a flush
  assign bubble = i_flush | ~i_valid;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_valid <= 1'b0;
      o_alu_result <= '0;
      o_dato_rt <= '0;
      o_reg_dst_addr <= '0;
      o_reg_write <= 1'b0;
      o_mem_read <= 1'b0;
      o_mem_write <= 1'b0;
      o_zero <= 1'b0;
      o_branch_taken <= 1'b0;
    end else if (i_flush || !i_stall) begin
      o_valid <= ~bubble;
      o_alu_result <= bubble ? '0 : result;
      o_dato_rt <= bubble ? '0 : rt;
      o_reg_dst_addr <= bubble ? '0 : i_reg_dst_addr;
      o_reg_write <= ~bubble & i_reg_write;
      o_mem_read <= ~bubble & i_mem_read;
      o_mem_write <= ~bubble & i_mem_write;
      o_zero <= ~bubble & zero;
      o_branch_taken <= ~bubble & i_branch & zero;
    end
endmodule

// File: tb/tb_etapa_ex.sv
// tb_etapa_ex: directed self-checking bench for etapa_ex
module tb_etapa_ex;
  logic clk = 1'b0, rst = 1'b1;
  logic valid, stall, flush, alu_src, shift_var, reg_write, mem_read, mem_write, branch, wb_reg_write;
  logic [3:0] alu_code;
  logic [31:0] dato_rs, dato_rt, imm, wb_data;
  logic [4:0] shamt, rs_addr, rt_addr, dst_addr, wb_addr;
  logic o_valid, o_reg_write, o_mem_read, o_mem_write, o_zero, o_branch_taken;
  logic [31:0] o_alu_result, o_dato_rt;
  logic [4:0] o_reg_dst_addr;
  int errors = 0, checks = 0;
  logic [31:0] exp_fwd;

  etapa_ex dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_alu_code(alu_code), .i_dato_rs(dato_rs), .i_dato_rt(dato_rt), .i_imm(imm), .i_shamt(shamt),
    .i_alu_src(alu_src), .i_shift_var(shift_var), .i_rs_addr(rs_addr), .i_rt_addr(rt_addr),
    .i_reg_dst_addr(dst_addr), .i_reg_write(reg_write), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_branch(branch), .i_wb_reg_write(wb_reg_write), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_valid(o_valid), .o_alu_result(o_alu_result), .o_dato_rt(o_dato_rt), .o_reg_dst_addr(o_reg_dst_addr),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_zero(o_zero), .o_branch_taken(o_branch_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    valid = 1'b1; stall = 1'b0; flush = 1'b0; alu_src = 1'b0; shift_var = 1'b0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0; wb_reg_write = 1'b0;
    alu_code = 4'b0110; dato_rs = '0; dato_rt = '0; imm = '0; wb_data = '0;
    shamt = '0; rs_addr = '0; rt_addr = '0; dst_addr = '0; wb_addr = '0;
  endtask

  task automatic op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    alu_code = code; dato_rs = a; dato_rt = b;
  endtask

  initial begin
    clear();
    op(4'b0110, 32'd5, 32'd7);
    reg_write = 1'b1; dst_addr = 5'd9;
    tick();
    tick();
    check("rst_valid", {31'b0, o_valid}, 0);
    check("rst_result", o_alu_result, 0);
    check("rst_dato_rt", o_dato_rt, 0);
    check("rst_ctrl", {o_reg_write, o_mem_read, o_mem_write, o_zero, o_branch_taken}, 0);
    rst = 1'b0;
    tick();
    check("load_result", o_alu_result, 32'd12);
    check("load_valid", {31'b0, o_valid}, 1);
    check("load_dato_rt", o_dato_rt, 32'd7);
    check("load_dst", {27'b0, o_reg_dst_addr}, 9);
    #2 rst = 1'b1;
    #1;
    check("async_rst_result", o_alu_result, 0);
    check("async_rst_valid", {31'b0, o_valid}, 0);
    #1 rst = 1'b0;
    #1;
    check("post_rst_hold", o_alu_result, 0);
    tick();
    check("post_rst_load", o_alu_result, 32'd12);
    // ALU sweep
    clear();
    op(4'b0010, 0, 32'h8000_0000); shamt = 5'd4;
    tick(); check("sra", o_alu_result, 32'hF800_0000);
    clear();
    op(4'b0001, 32'd36, 32'hF0); shift_var = 1'b1; shamt = 5'd17;
    tick(); check("srlv", o_alu_result, 32'h0F);
    clear();
    op(4'b0011, 0, 32'hDEAD_BEEF); alu_src = 1'b1; imm = 32'h1234;
    tick(); check("lui", o_alu_result, 32'h1234_0000);
    clear();
    op(4'b1100, 32'hFFFF_FFFF, 32'd1);
    tick(); check("slt_neg", o_alu_result, 32'd1);
    op(4'b1100, 32'd1, 32'hFFFF_FFFF);
    tick(); check("slt_pos", o_alu_result, 32'd0);
    op(4'b1011, 0, 0);
    tick(); check("nor", o_alu_result, 32'hFFFF_FFFF);
    op(4'b0111, 32'd3, 32'd5);
    tick(); check("subu_wrap", o_alu_result, 32'hFFFF_FFFE);
    op(4'b0000, 0, 32'h3); shamt = 5'd31;
    tick(); check("sll", o_alu_result, 32'h8000_0000);
    op(4'b1000, 32'hF0F0, 32'hFF00);
    tick(); check("and", o_alu_result, 32'hF000);
    op(4'b1001, 32'hF0F0, 32'hFF00);
    tick(); check("or", o_alu_result, 32'hFFF0);
    op(4'b1010, 32'hF0F0, 32'hFF00);
    tick(); check("xor", o_alu_result, 32'h0FF0);
    op(4'b0100, 32'h11, 32'h22);
    tick(); check("undef", o_alu_result, 0);
    check("undef_zero", {31'b0, o_zero}, 1);
    // stall then flush
    clear();
    op(4'b0110, 32'd4, 32'd5); reg_write = 1'b1; mem_write = 1'b1; dst_addr = 5'd7;
    tick(); check("pre_stall", o_alu_result, 32'd9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dato_rs = 32'd100 + i; dst_addr = 5'd12;
      tick();
      check("stall_result", o_alu_result, 32'd9);
      check("stall_dst", {27'b0, o_reg_dst_addr}, 7);
    end
    flush = 1'b1;
    tick();
    check("flush_valid", {31'b0, o_valid}, 0);
    check("flush_ctrl", {o_reg_write, o_mem_read, o_mem_write, o_zero, o_branch_taken}, 0);
    check("flush_result", o_alu_result, 0);
    clear();
    op(4'b0110, 32'd1, 32'd1); valid = 1'b0; reg_write = 1'b1; mem_write = 1'b1;
    tick();
    check("invalid_ctrl", {o_valid, o_reg_write, o_mem_write}, 0);
    // branch
    clear();
    op(4'b0111, 32'h55, 32'h55); branch = 1'b1;
    tick();
    check("beq_zero", {31'b0, o_zero}, 1);
    check("beq_taken", {31'b0, o_branch_taken}, 1);
    dato_rt = 32'h56;
    tick();
    check("bne_zero", {31'b0, o_zero}, 0);
    check("bne_taken", {31'b0, o_branch_taken}, 0);
    dato_rt = 32'h55; valid = 1'b0;
    tick();
    check("beq_invalid", {31'b0, o_branch_taken}, 0);
    // forwarding
    clear();
    op(4'b0110, 32'd10, 0); reg_write = 1'b1; dst_addr = 5'd3;
    tick(); check("fwd_r3", o_alu_result, 32'd10);
    op(4'b0110, 0, 0); rs_addr = 5'd3; alu_src = 1'b1; imm = 32'd1; dst_addr = 5'd5;
    tick();
`ifdef EX_FORWARDING_EN
    exp_fwd = 32'd11;
`else
    exp_fwd = 32'd1;
`endif
    check("fwd_b2b", o_alu_result, exp_fwd);
    wb_reg_write = 1'b1; wb_addr = 5'd3; wb_data = 32'd20; dst_addr = 5'd3;
    tick();
`ifdef EX_FORWARDING_EN
    exp_fwd = 32'd21;
`else
    exp_fwd = 32'd1;
`endif
    check("fwd_dist2", o_alu_result, exp_fwd);
    dst_addr = 5'd8;
    tick();
`ifdef EX_FORWARDING_EN
    exp_fwd = 32'd22;
`else
    exp_fwd = 32'd1;
`endif
    check("fwd_ex_prio", o_alu_result, exp_fwd);
    clear();
    op(4'b0110, 32'd50, 0); reg_write = 1'b1; dst_addr = 5'd0;
    tick(); check("r0_write", o_alu_result, 32'd50);
    op(4'b0110, 32'd7, 0); rs_addr = 5'd0; alu_src = 1'b1; imm = 32'd1; dst_addr = 5'd6;
    tick(); check("r0_nofwd", o_alu_result, 32'd8);
    clear();
    op(4'b0110, 32'd100, 0); alu_src = 1'b1; imm = 32'd4; reg_write = 1'b1; mem_read = 1'b1; dst_addr = 5'd3;
    tick();
    check("lw_addr", o_alu_result, 32'd104);
    check("lw_mem_read", {31'b0, o_mem_read}, 1);
    op(4'b0110, 32'd30, 0); mem_read = 1'b0; rs_addr = 5'd3; imm = 32'd1; dst_addr = 5'd6;
    tick(); check("lw_nofwd", o_alu_result, 32'd31);
    op(4'b0110, 0, 0); rs_addr = 5'd0; rt_addr = 5'd6; imm = 32'd0; mem_write = 1'b1; reg_write = 1'b0;
    tick();
`ifdef EX_FORWARDING_EN
    exp_fwd = 32'd31;
`else
    exp_fwd = 32'd0;
`endif
    check("fwd_store_rt", o_dato_rt, exp_fwd);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
